// File: rtl/dlx_decode.sv
// DLX instruction decode stage: field extraction, write-back bypass, load-use
// hazard detection and the ID/EX pipeline register.
module dlx_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    output logic [4:0]  Rs1,
    output logic [4:0]  Rs2,
    input  logic [31:0] S1,
    input  logic [31:0] S2,
    input  logic        WB,
    input  logic [4:0]  Rd,
    input  logic [31:0] reg_s,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [5:0]  ex_op,
    output logic [10:0] ex_func,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic        ex_wb,
    output logic        ex_load,
    output logic [31:0] ex_pc,
    output logic [15:0] stall_cnt
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQZ  = 6'h04,
        OP_BNEZ  = 6'h05,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_JR    = 6'h12,
        OP_LB    = 6'h20,
        OP_LH    = 6'h21,
        OP_LW    = 6'h23,
        OP_LBU   = 6'h24,
        OP_LHU   = 6'h25,
        OP_SB    = 6'h28,
        OP_SH    = 6'h29,
        OP_SW    = 6'h2B
    } opcode_e;

    logic [5:0]  op;
    logic        is_r, is_jump, is_store, is_load, no_wb_op;
    logic        use_rs1, use_rs2;
    logic [4:0]  dest;
    logic        dec_wb;
    logic [31:0] dec_imm;
    logic [10:0] dec_func;
    logic [31:0] opnd_a, opnd_b;
    logic        hold, hazard;

    logic        ex_valid_q, ex_valid_d;
    logic [5:0]  ex_op_q, ex_op_d;
    logic [10:0] ex_func_q, ex_func_d;
    logic [31:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_imm_q, ex_imm_d, ex_pc_q, ex_pc_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic        ex_wb_q, ex_wb_d, ex_load_q, ex_load_d;
    logic [15:0] stall_q, stall_d;

    assign op  = if_instr[31:26];
    assign Rs1 = if_instr[25:21];
    assign Rs2 = if_instr[20:16];

    always_comb begin
        is_r     = (op == OP_RTYPE);
        is_jump  = (op == OP_J) || (op == OP_JAL);
        is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        is_load  = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
                   (op == OP_LBU) || (op == OP_LHU);
        no_wb_op = is_store || (op == OP_BEQZ) || (op == OP_BNEZ) ||
                   (op == OP_J) || (op == OP_JR);
        use_rs1  = !is_jump;
        use_rs2  = is_r || is_store;

        if (is_r)              dest = if_instr[15:11];
        else if (op == OP_JAL) dest = 5'd31;
        else                   dest = if_instr[20:16];
        dec_wb = !no_wb_op && (dest != 5'd0);

        if (is_jump)
            dec_imm = {{6{if_instr[25]}}, if_instr[25:0]};
        else if ((op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI))
            dec_imm = {16'h0000, if_instr[15:0]};
        else
            dec_imm = {{16{if_instr[15]}}, if_instr[15:0]};

        dec_func = is_r ? if_instr[10:0] : '0;

        // r0 reads as zero even if the write-back port targets it
        if (Rs1 == 5'd0)              opnd_a = '0;
        else if (WB && (Rd == Rs1))   opnd_a = reg_s;
        else                          opnd_a = S1;
        if (Rs2 == 5'd0)              opnd_b = '0;
        else if (WB && (Rd == Rs2))   opnd_b = reg_s;
        else                          opnd_b = S2;
    end

    assign hold   = ex_valid_q && !ex_ready;
    assign hazard = if_valid && ex_valid_q && ex_load_q && ex_wb_q && (ex_rd_q != 5'd0) &&
                    ((use_rs1 && (ex_rd_q == Rs1)) || (use_rs2 && (ex_rd_q == Rs2)));
    assign id_ready = flush || (!hold && !hazard);

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        ex_func_d  = ex_func_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_imm_d   = ex_imm_q;
        ex_rd_d    = ex_rd_q;
        ex_wb_d    = ex_wb_q;
        ex_load_d  = ex_load_q;
        ex_pc_d    = ex_pc_q;
        stall_d    = stall_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (hold) begin
            ex_valid_d = ex_valid_q;
        end else if (hazard) begin
            ex_valid_d = 1'b0;
            if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
        end else if (if_valid) begin
            ex_valid_d = 1'b1;
            ex_op_d    = op;
            ex_func_d  = dec_func;
            ex_a_d     = opnd_a;
            ex_b_d     = opnd_b;
            ex_imm_d   = dec_imm;
            ex_rd_d    = dest;
            ex_wb_d    = dec_wb;
            ex_load_d  = is_load;
            ex_pc_d    = if_pc;
        end else begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_func_q  <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_imm_q   <= '0;
            ex_rd_q    <= '0;
            ex_wb_q    <= 1'b0;
            ex_load_q  <= 1'b0;
            ex_pc_q    <= '0;
            stall_q    <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            ex_func_q  <= ex_func_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_imm_q   <= ex_imm_d;
            ex_rd_q    <= ex_rd_d;
            ex_wb_q    <= ex_wb_d;
            ex_load_q  <= ex_load_d;
            ex_pc_q    <= ex_pc_d;
            stall_q    <= stall_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_op     = ex_op_q;
    assign ex_func   = ex_func_q;
    assign ex_a      = ex_a_q;
    assign ex_b      = ex_b_q;
    assign ex_imm    = ex_imm_q;
    assign ex_rd     = ex_rd_q;
    assign ex_wb     = ex_wb_q;
    assign ex_load   = ex_load_q;
    assign ex_pc     = ex_pc_q;
    assign stall_cnt = stall_q;

endmodule

// File: doc/dlx_decode.md
DLX_DECODE -- requirements
Module: dlx_decode

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; all state is rising-edge clocked.
REQ-002 clk  in  1  system clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 if_valid  in  1  IF/ID holds a valid instruction.
REQ-005 if_instr  in  32  instruction; held stable by upstream while id_ready=0.
REQ-006 if_pc  in  32  PC of if_instr.
REQ-007 id_ready  out  1  instruction consumed this cycle.
REQ-008 Rs1, Rs2  out  5 each  regs read addresses.
REQ-009 S1, S2  in  32 each  regs read data, combinational from Rs1/Rs2.
REQ-010 WB  in  1, Rd  in  5, reg_s  in  32  write-back port shared with regs.
REQ-011 flush  in  1  taken branch/jump in EX.
REQ-012 ex_ready  in  1  EX accepts ID/EX contents.
REQ-013 ex_valid 1, ex_op 6, ex_func 11, ex_a 32, ex_b 32, ex_imm 32, ex_rd 5, ex_wb 1, ex_load 1, ex_pc 32  out  ID/EX pipeline register.
REQ-014 stall_cnt  out  16  load-use stall counter.

Function
REQ-015 Decode: op=if_instr[31:26]; Rs1=[25:21]; Rs2=[20:16]; R-type op=0x00, func=[10:0], else ex_func=0.
REQ-016 Destination: R-type [15:11]; loads and I-type ALU [20:16]; jal (0x03) 31.
REQ-017 Write enable: ex_wb=0 for stores (0x28,0x29,0x2B), beqz/bnez (0x04,0x05), j (0x02), jr (0x12), or dest==0; else 1.
REQ-018 Load: ex_load=1 for op in {0x20,0x21,0x23,0x24,0x25}.
REQ-019 Immediate: j/jal sign-extend [25:0]; andi/ori/xori (0x0C-0x0E) zero-extend [15:0]; all others sign-extend [15:0].
REQ-020 Source use: rs1 used unless j/jal; rs2 used for R-type and stores.
REQ-021 Write-back bypass: ex_a=reg_s when WB=1, Rd==Rs1, Rd!=0, else S1; same for ex_b with Rs2/S2.
REQ-022 Operands for register 0 SHALL be 0 regardless of S1/S2 or bypass.
REQ-023 hold = ex_valid & ~ex_ready.
REQ-024 hazard = if_valid & ex_valid & ex_load & ex_wb & ex_rd!=0 & ex_rd matches a used source (REQ-020).
REQ-025 id_ready = flush | (~hold & ~hazard), combinational.
REQ-026 Per-cycle priority: flush -> ex_valid<=0; else hold -> all ex_* unchanged; else hazard -> ex_valid<=0 (bubble), stall_cnt+1; else if_valid -> load decoded fields, ex_valid<=1; else ex_valid<=0.
REQ-027 ex_* fields other than ex_valid are don't-care when ex_valid=0 but SHALL NOT change under hold.
REQ-028 stall_cnt SHALL saturate at 0xFFFF.
REQ-029 Hazard resolves by itself: after one bubble ex_load's entry advances and the instruction issues next cycle with bypass/regs data; a held load SHALL keep hazard asserted.
REQ-030 flush concurrent with hazard or hold: flush wins, no stall_cnt increment.
REQ-031 Latency: instruction accepted at edge N is visible on ex_* after edge N.

Reset
REQ-032 rst=1 SHALL immediately force ex_valid=0, all other ex_* and stall_cnt to 0, independent of clk.
REQ-033 rst asserted mid-hold or mid-stall SHALL discard the ID/EX contents; after deassert id_ready follows REQ-025 with ex_valid=0.

Verification
REQ-034 add r3,r1,r2 (0x00221820), S1=5, S2=7 -> next cycle ex_valid=1, ex_a=5, ex_b=7, ex_rd=3, ex_wb=1, ex_func=0x020.
REQ-035 lw r7,0(r1) then add r4,r7,r2 -> one bubble (ex_valid=0, id_ready=0), stall_cnt=1, add issues next cycle.
REQ-036 WB=1, Rd=7, reg_s=111111, S1=0, Rs1=7 -> ex_a=111111; same with Rd=0 -> ex_a=0.
REQ-037 ori r5,r0,0x8000 -> ex_imm=0x00008000; addi r5,r0,0x8000 -> ex_imm=0xFFFF8000; jal -4 -> ex_rd=31, ex_imm=0xFFFFFFFC.
REQ-038 ex_ready=0 for 3 cycles with new if_instr -> ex_* constant, id_ready=0; flush in cycle 2 -> ex_valid=0, id_ready=1.
REQ-039 rst pulse mid-stall -> ex_valid=0 and stall_cnt=0 before next clk edge.
